// File: rtl/keypad_display_ctrl.sv
// keypad_display_ctrl: 4x4 keypad scan/debounce into an N-digit hex buffer, muxed onto a 7-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module keypad_display_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_HZ         = 100_000_000,
   parameter int TICK_HZ        = 1000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              row,
   output logic [3:0]              col,
   input  logic                    clr,
   output logic                    key_valid,
   output logic [3:0]              key_code,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int TW  = $clog2(DIV);
   localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int W   = 4 * NUM_DIGITS;
   // nibble {row,col} of KEY_MAP is the key value; 7-bit entry n of SEG_MAP is the glyph for hex n
   localparam logic [63:0]  KEY_MAP = 64'hDEF0_C987_B654_A321;
   localparam logic [111:0] SEG_MAP = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                       7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [3:0]      row_s1_q, row_s2_q;
   logic [3:0]      col_q, col_d;
   logic [1:0]      key_row_q, key_row_d, key_col_q, key_col_d;
   logic [7:0]      cnt_q, cnt_d, cnt_inc;
   logic            key_valid_q, key_valid_d;
   logic [3:0]      key_code_q, key_code_d;
   logic [W-1:0]    digits_q, digits_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [6:0]      seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic            tick, any, accept, blank;
   logic [1:0]      row_idx, col_idx;
   logic [3:0]      key, nib;

   always_comb begin
      tick       = tick_cnt_q == TW'(DIV - 1);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      any        = ~&row_s2_q;
      row_idx    = !row_s2_q[0] ? 2'd0 : !row_s2_q[1] ? 2'd1 : !row_s2_q[2] ? 2'd2 : 2'd3;
      col_idx    = !col_q[0] ? 2'd0 : !col_q[1] ? 2'd1 : !col_q[2] ? 2'd2 : 2'd3;
      key        = KEY_MAP[4*{key_row_q, key_col_q} +: 4];
      cnt_inc    = cnt_q + 8'd1;
      state_d    = state_q;
      col_d      = col_q;
      key_row_d  = key_row_q;
      key_col_d  = key_col_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      if (tick)
         case (state_q)
            SCAN:
               if (any) begin
                  state_d   = DEBOUNCE;
                  key_row_d = row_idx;
                  key_col_d = col_idx;
                  cnt_d     = '0;
               end else
                  col_d = {col_q[2:0], col_q[3]};
            DEBOUNCE:
               if (any && row_idx == key_row_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == 8'(DEBOUNCE_TICKS)) begin
                     accept  = 1'b1;
                     state_d = HOLD;
                  end
               end else
                  state_d = SCAN;
            HOLD:
               if (!any) begin
                  cnt_d   = '0;
                  state_d = RELEASE;
               end
            RELEASE:
               if (any)
                  state_d = HOLD;
               else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == 8'(DEBOUNCE_TICKS)) begin
                     state_d = SCAN;
                     col_d   = {col_q[2:0], col_q[3]};
                  end
               end
            default: state_d = SCAN;
         endcase
   end

   always_comb begin
      key_valid_d = accept;
      key_code_d  = accept ? key : key_code_q;
      digits_d    = clr ? '0 : accept ? (digits_q << 4) | W'(key) : digits_q;
      idx_d       = tick ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
      nib         = digits_q[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      blank       = idx_d != '0 && (digits_q >> (4*idx_d)) == '0;
`else
      blank       = 1'b0;
`endif
      an_d        = tick ? (blank ? '1 : ~(NUM_DIGITS'(1) << idx_d)) : an_q;
      seg_d       = tick ? (blank ? 7'h7F : SEG_MAP[7*nib +: 7]) : seg_q;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tick_cnt_q  <= '0;
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         state_q     <= SCAN;
         col_q       <= 4'b1110;
         key_row_q   <= '0;
         key_col_q   <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         digits_q    <= '0;
         idx_q       <= '0;
         seg_q       <= 7'h40;
         an_q        <= ~NUM_DIGITS'(1);
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         row_s1_q    <= row;
         row_s2_q    <= row_s1_q;
         state_q     <= state_d;
         col_q       <= col_d;
         key_row_q   <= key_row_d;
         key_col_q   <= key_col_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         digits_q    <= digits_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign digits    = digits_q;
   assign seg       = seg_q;
   assign an        = an_q;
endmodule

// File: tb/tb_keypad_display_ctrl.sv
// tb_keypad_display_ctrl: keypad model drives rows from col; accepted keys are checked against a scoreboard queue.
module tb_keypad_display_ctrl;
   typedef struct packed {
      logic [3:0]  key;
      logic [15:0] dig;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, clr, active;
   logic [1:0]  prow, pcol;
   logic [3:0]  row, col, key_code;
   logic        key_valid;
   logic [15:0] digits, exp_digits, rot_seq;
   logic [6:0]  seg;
   logic [3:0]  an;
   exp_t        sb[$];
   exp_t        got_e;
   int          n_checks = 0, n_errors = 0;
   int          bcnt, bidx;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   keypad_display_ctrl #(.NUM_DIGITS(4), .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(3)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col), .clr(clr), .key_valid(key_valid),
      .key_code(key_code), .digits(digits), .seg(seg), .an(an));

   always #5 clk = ~clk;

   // a pressed key pulls its row low only while its column is driven
   assign row = (active && !col[pcol]) ? ~(4'b0001 << prow) : 4'hF;

   // tick phase and display slot as seen from the pins: tick every 10th clk after reset
   always @(posedge clk or negedge reset)
      if (!reset) begin
         bcnt <= 0;
         bidx <= 0;
      end else begin
         bcnt <= (bcnt == 9) ? 0 : bcnt + 1;
         if (bcnt == 9) bidx <= (bidx + 1) % 4;
      end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (reset && key_valid) begin
         if (sb.size() == 0) check("kv_spurious", 32'(key_valid), 32'd0);
         else begin
            got_e = sb.pop_front();
            check("key_code", 32'(key_code), 32'(got_e.key));
            check("kv_digits", 32'(digits), 32'(got_e.dig));
         end
      end

   task automatic wait_tick(int n);
      for (int i = 0; i < n; i++)
         do @(negedge clk); while (bcnt != 0);
   endtask

   task automatic wait_col(logic [3:0] tgt);
      for (int i = 0; i < 8; i++) begin
         wait_tick(1);
         if (col == tgt) break;
      end
      check("col_sync", 32'(col), 32'(tgt));
   endtask

   task automatic press(logic [1:0] r, logic [1:0] c, logic [3:0] k);
      exp_digits = {exp_digits[11:0], k};
      sb.push_back({k, exp_digits});
      prow = r;
      pcol = c;
      active = 1'b1;
      wait_tick(10);
      active = 1'b0;
      wait_tick(5);
      check("accept_seen", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_digits = '0;
   endtask

   initial begin
      logic [3:0] nibv, exp_an;
      logic [6:0] exp_seg;
      logic       blank;
      reset = 1'b0; clr = 1'b0; active = 1'b0; prow = '0; pcol = '0; exp_digits = '0;
      rot_seq = 16'hDB7E;
      repeat (3) @(negedge clk);
      check("rst_col", 32'(col), 32'hE);
      check("rst_an", 32'(an), 32'hE);
      check("rst_seg", 32'(seg), 32'h40);
      check("rst_digits", 32'(digits), 32'h0);
      check("rst_kv", 32'(key_valid), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_tick(1);
         check("col_rot", 32'(col), 32'(rot_seq[4*(3-i) +: 4]));
      end

      press(2'd2, 2'd1, 4'h8);
      check("single", 32'(digits), 32'h0008);

      pulse_clr();
      check("clr", 32'(digits), 32'h0);
      press(2'd0, 2'd0, 4'h1);
      press(2'd0, 2'd1, 4'h2);
      press(2'd0, 2'd2, 4'h3);
      press(2'd0, 2'd3, 4'hA);
      check("shift4", 32'(digits), 32'h123A);
      press(2'd1, 2'd1, 4'h5);
      check("overflow", 32'(digits), 32'h23A5);

      wait_col(4'b1110);
      prow = 2'd0; pcol = 2'd0; active = 1'b1;
      wait_tick(2);
      active = 1'b0;
      wait_tick(5);
      check("bounce", 32'(digits), 32'h23A5);

      // clr lands on the clk edge that registers the accept: detection at T+1, accept at T+4
      wait_col(4'b1110);
      exp_digits = '0;
      sb.push_back({4'h4, 16'h0});
      prow = 2'd1; pcol = 2'd0; active = 1'b1;
      wait_tick(3);
      repeat (9) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      wait_tick(6);
      active = 1'b0;
      wait_tick(5);
      check("clr_hit_seen", 32'(sb.size()), 32'd0);
      sb.delete();
      check("clr_hit_dig", 32'(digits), 32'h0);

      press(2'd2, 2'd0, 4'h7);
      for (int i = 0; i < 8; i++) begin
         wait_tick(1);
         nibv = exp_digits[4*bidx +: 4];
         blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank = bidx > 0 && (exp_digits >> (4*bidx)) == '0;
`endif
         exp_an = blank ? 4'hF : ~(4'b0001 << bidx);
         exp_seg = blank ? 7'h7F : seg_tab[nibv];
         check("disp_an", 32'(an), 32'(exp_an));
         check("disp_seg", 32'(seg), 32'(exp_seg));
      end

      exp_digits = {exp_digits[11:0], 4'h9};
      sb.push_back({4'h9, exp_digits});
      prow = 2'd2; pcol = 2'd2; active = 1'b1;
      wait_tick(10);
      check("hold_seen", 32'(sb.size()), 32'd0);
      sb.delete();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_dig", 32'(digits), 32'h0);
      exp_digits = 16'h0009;
      sb.push_back({4'h9, exp_digits});
      reset = 1'b1;
      wait_tick(10);
      active = 1'b0;
      wait_tick(5);
      check("reaccept_seen", 32'(sb.size()), 32'd0);
      sb.delete();
      check("reaccept_dig", 32'(digits), 32'h0009);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
